// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  input  logic                       err_clr,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_AF    = CW'(AF_LVL);
  localparam logic [CW-1:0] L_AE    = CW'(AE_LVL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_unf;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == '0);
  // A write into a full FIFO is allowed when the same edge frees a slot.
  assign w_rd_ok = rd_en && !w_empty;
  assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set wins over clear when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr_en && !w_wr_ok)   r_ovf <= 1'b1;
      else if (err_clr)        r_ovf <= 1'b0;
      if (rd_en && !w_rd_ok)   r_unf <= 1'b1;
      else if (err_clr)        r_unf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign dout       = r_mem[r_rd_ptr];
  assign dout_valid = !w_empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
`endif

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= L_AF);
  assign almost_empty = (r_count <= L_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
